// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer of
// (pc, inst) pairs with valid/ready on both sides and a single-cycle flush.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CW-1:0]     count
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    entry_t         mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q,  count_d;

    logic           full, empty;
    logic           push, pop;
    entry_t         wr_entry;
    entry_t         head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // if_ready is the only output allowed to see rst combinationally.
    assign if_ready = rst & ~full;
    assign id_valid = ~empty;

    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    assign wr_entry.pc   = if_pc;
    assign wr_entry.inst = if_inst;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; emptiness is tracked purely by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_comb begin
        head = '0;
        if (!empty) head = mem_q[rd_ptr_q];
    end

    assign id_pc   = head.pc;
    assign id_inst = head.inst;
    assign count   = count_q;

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction queue between fetch and decode: the successor to the single-entry IF/ID pipeline register. It holds up to DEPTH fetched (pc, inst) pairs and transfers them with valid/ready handshakes on both sides. A flush discards every buffered entry for branch redirects, and an empty queue presents a zero pair (nop) to decode. It sits between the fetch stage and the decode stage, and absorbs fetch/decode rate mismatch and decode stalls.

## Interface
- ADDR_W, 32, width of pc field
- INST_W, 32, width of instruction field
- DEPTH, 4, number of entries; power of two, >= 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- if_valid  in  1  fetch offers an entry this cycle
- if_ready  out  1  queue accepts an entry this cycle
- if_pc  in  ADDR_W  pc of offered entry
- if_inst  in  INST_W  instruction of offered entry
- flush  in  1  discard all entries (branch redirect / exception)
- id_valid  out  1  head entry presented to decode
- id_ready  in  1  decode consumes head this cycle
- id_pc  out  ADDR_W  pc of head entry; 0 when empty
- id_inst  out  INST_W  instruction of head entry; 0 when empty
- count  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH

## Operation
- Storage: DEPTH-entry circular buffer with rd_ptr and wr_ptr, each log2(DEPTH) bits, plus the occupancy counter `count`.
- Pointer wrap: modulo DEPTH by natural overflow. Empty is count==0; full is count==DEPTH.
- if_ready = (count != DEPTH) and rst deasserted. if_ready is 0 while rst is low.
- push = if_valid & if_ready & !flush. On push, store the pair at wr_ptr and increment wr_ptr.
- id_valid = (count != 0).
- id_pc/id_inst = entry at rd_ptr when id_valid, otherwise all zero.
- pop = id_valid & id_ready & !flush. On pop, increment rd_ptr.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Push and pop in the same cycle are allowed at any occupancy except full. When full, if_ready is 0, so no push occurs; a pop when full leaves count = DEPTH-1.
- No bypass: an entry pushed into an empty queue is not visible at the output until the next cycle.
- flush has priority over everything. In a flush cycle:
  - rd_ptr, wr_ptr and count are cleared to 0.
  - Any same-cycle push is discarded.
  - Any same-cycle pop has no effect.
  - Storage contents need not be cleared.
- Protocol violations are absorbed: if_valid while full and id_ready while empty are ignored, with no state change.
- Outputs depend only on registered state, except if_ready, which also depends on rst. There is no combinational path from if_* or id_ready to any output.

## Timing
- Reset (rst low, asynchronous):
  - Immediately: rd_ptr=0, wr_ptr=0, count=0, id_valid=0, id_pc=0, id_inst=0, if_ready=0.
  - Storage contents are don't-care.
- After release: if_ready=1 from the first cycle rst is high. The first push can occur on the first rising edge with rst high.
- Reset asserted mid-operation: all entries are lost immediately; outputs go to the reset values without waiting for a clock edge.
- Latency: an entry pushed at edge N appears at id_* with id_valid=1 after edge N. With id_ready held 1 and no flush, it leaves at edge N+1.
- Throughput: one push and one pop per cycle, sustained at any occupancy 1..DEPTH-1.
- Flush at edge N: after edge N, id_valid=0, id_pc=0, id_inst=0, count=0, if_ready=1. The next push is accepted at edge N+1.
- Order: entries leave in push order. A pc/inst pair is never split or reordered.

## Test plan
- Reset and first push: hold rst low, then release. Offer pc=0x0000_0100, inst=0x3401_1100 at edge 1. Required:
  - while reset: id_valid=0, id_pc=0, if_ready=0
  - after edge 1: id_valid=1, id_pc=0x100, id_inst=0x3401_1100, count=1
- Fill and stall: id_ready=0, push pc 0x100,0x104,0x108,0x10C. Required:
  - count=4, if_ready=0
  - a fifth offer of 0x110 is ignored
  - then id_ready=1 drains 0x100..0x10C in order, one per cycle, ending with count=0 and id_pc=0
- Streaming: if_valid=1 and id_ready=1 for 20 cycles with pc incrementing by 4. Required:
  - count stays 1
  - id_pc lags if_pc by exactly one cycle
  - no entry is lost or duplicated
- Flush with a simultaneous push and pop: count=3, flush=1, if_valid=1 (pc=0x200), id_ready=1. Required:
  - after the edge: count=0, id_valid=0
  - 0x200 is never presented
  - the next push of 0x300 appears one cycle later
- Asynchronous reset mid-stream: drop rst between edges with count=2. Required:
  - id_valid, id_pc, id_inst and count go to 0 before the next edge
  - after release, the queue operates normally, starting empty
